// File: rtl/decode_regfile_stage.sv
// decode_regfile_stage: MIPS instruction decode with an integrated 32x32
// register file. It presents a registered operand bundle to the ALU.
// The upstream side uses a valid/ready handshake, and a writeback port
// updates the register file.
// Optional feature macro: REGFILE_BYPASS_EN.
//   When defined, a writeback on the capture edge is forwarded into the
//   bundle, and a writeback during a stall refreshes the held rs/rt contents.
//   When undefined, captures see the pre-write value and held contents are frozen.
module decode_regfile_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [4:0]  shamt,
    output logic [31:0] rs_content,
    output logic [31:0] rt_content,
    output logic [31:0] imme32,
    output logic [4:0]  dest_addr,
    output logic        reg_write,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic [31:0] rs_content;
        logic [31:0] rt_content;
        logic [31:0] imme32;
        logic [4:0]  dest_addr;
        logic        reg_write;
    } bundle_t;

    logic [31:0] gpr [32];
    bundle_t     bundle_q, bundle_d;
    logic        vld_q;

    logic [5:0]  op;
    logic [4:0]  rs_a, rt_a, rd_a, dest;
    logic        wb_hit;

`ifdef REGFILE_BYPASS_EN
    // Source addresses of the held bundle, needed to refresh it while stalled.
    logic [4:0]  rs_a_q, rt_a_q;
`endif

    assign op     = instr[31:26];
    assign rs_a   = instr[25:21];
    assign rt_a   = instr[20:16];
    assign rd_a   = instr[15:11];
    assign dest   = (op == OP_RTYPE) ? rd_a : rt_a;
    // Writes to $0 are dropped, so $0 stays zero from reset onward.
    assign wb_hit = wb_en && (wb_addr != 5'd0);

    assign in_ready  = !vld_q || out_ready;
    assign out_valid = vld_q;

    assign opcode     = bundle_q.opcode;
    assign funct      = bundle_q.funct;
    assign shamt      = bundle_q.shamt;
    assign rs_content = bundle_q.rs_content;
    assign rt_content = bundle_q.rt_content;
    assign imme32     = bundle_q.imme32;
    assign dest_addr  = bundle_q.dest_addr;
    assign reg_write  = bundle_q.reg_write;

    // Decode the incoming instruction into the next bundle, including the register reads.
    always_comb begin
        bundle_d            = '0;
        bundle_d.opcode     = op;
        bundle_d.funct      = instr[5:0];
        bundle_d.shamt      = instr[10:6];
        bundle_d.rs_content = gpr[rs_a];
        bundle_d.rt_content = gpr[rt_a];
`ifdef REGFILE_BYPASS_EN
        if (wb_hit && (wb_addr == rs_a)) bundle_d.rs_content = wb_data;
        if (wb_hit && (wb_addr == rt_a)) bundle_d.rt_content = wb_data;
`endif
        // Logical immediates are zero-extended; all other opcodes, including unknown ones, are sign-extended.
        if (op == OP_ANDI || op == OP_ORI || op == OP_XORI)
            bundle_d.imme32 = {16'h0000, instr[15:0]};
        else
            bundle_d.imme32 = {{16{instr[15]}}, instr[15:0]};
        bundle_d.dest_addr  = dest;
        bundle_d.reg_write  = !(op == OP_SW || op == OP_BEQ || op == OP_BNE)
                              && (dest != 5'd0);
    end

    // Register file: reset clears every entry, and writebacks are ignored during reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) gpr[i] <= '0;
        end else if (wb_hit) begin
            gpr[wb_addr] <= wb_data;
        end
    end

    // Output bundle register: capture on input transfer, drop valid on an idle slot, and hold while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q    <= 1'b0;
            bundle_q <= '0;
`ifdef REGFILE_BYPASS_EN
            rs_a_q   <= '0;
            rt_a_q   <= '0;
`endif
        end else if (in_ready) begin
            vld_q <= in_valid;
            if (in_valid) begin
                bundle_q <= bundle_d;
`ifdef REGFILE_BYPASS_EN
                rs_a_q   <= rs_a;
                rt_a_q   <= rt_a;
`endif
            end
`ifdef REGFILE_BYPASS_EN
        end else if (wb_hit) begin
            if (wb_addr == rs_a_q) bundle_q.rs_content <= wb_data;
            if (wb_addr == rt_a_q) bundle_q.rt_content <= wb_data;
`endif
        end
    end

endmodule
